// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM states and
// default instruction-memory geometry.
package cpu_pkg;

  localparam int IMEM_ADDR_W    = 10;
  localparam int IMEM_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the byte stream is being consumed.
  function automatic logic is_loading(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses for one
// cycle after the fourth byte of each word is shifted in.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sh;

  assign last_byte = (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 2'd0;
      sh         <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        cnt <= 2'd0;
      end else if (shift_en) begin
        sh  <= {sh[15:0], din};
        cnt <= cnt + 2'd1;
        if (last_byte) begin
          word       <= {sh, din};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from a byte stream
// into instruction memory and holds the CPU in reset until the image verifies.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t          state, state_next;
  logic [7:0]      chk;
  logic [7:0]      len_hi;
  logic [15:0]     len_reg;
  logic            accept;
  logic            load_start;
  logic            last_byte;
  logic [ADDR_W:0] words_inc;

  assign in_ready   = is_loading(state);
  assign accept     = in_valid & in_ready;
  assign load_start = start & ~is_loading(state);
  assign words_inc  = words_loaded + 1'b1;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_start),
    .shift_en  (accept && (state == ST_DATA)),
    .din       (in_data),
    .last_byte (last_byte),
    .word_valid(imem_we),
    .word      (imem_wdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_hi, in_data} > MAX_LEN) state_next = ST_ERR;
          else if ({len_hi, in_data} == 16'd0)   state_next = ST_CHK;
          else                                   state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && last_byte && (16'(words_inc) == len_reg)) state_next = ST_CHK;
      end
      ST_CHK: begin
        if (accept) state_next = (in_data == chk) ? ST_DONE : ST_ERR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change together
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      chk          <= 8'd0;
      len_hi       <= 8'd0;
      len_reg      <= 16'd0;
      words_loaded <= '0;
      imem_addr    <= '0;
    end else begin
      state   <= state_next;
      cpu_rst <= (state_next != ST_DONE);
      done    <= (state_next == ST_DONE);
      err     <= (state_next == ST_ERR);
      if (load_start) begin
        chk          <= 8'd0;
        words_loaded <= '0;
      end else if (accept) begin
        if (state != ST_CHK)    chk     <= chk ^ in_data;
        if (state == ST_LEN_HI) len_hi  <= in_data;
        if (state == ST_LEN_LO) len_reg <= {len_hi, in_data};
        if ((state == ST_DATA) && last_byte) begin
          imem_addr    <= words_loaded[ADDR_W-1:0];
          words_loaded <= words_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame-level test of imem_loader against a behavioural frame model.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int  n_checks = 0;
  int  n_fails  = 0;
  wr_t exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory writes must match the model's queue, in order; the CPU may run
  // exactly when a verified image is present.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_imem_we", {22'd0, imem_addr}, 32'hFFFF_FFFF);
        end else begin
          check("imem_addr", {22'd0, imem_addr}, {22'd0, exp_q[0].addr});
          check("imem_wdata", imem_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
      check("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, ~done});
    end
  end

  // Frame model: expected writes are queued; returns bytes the loader will
  // consume and the terminal status.
  task automatic model_frame(input bq_t f, output int consumed, output bit exp_done,
                             output bit exp_err, output int exp_words);
    int n;
    logic [7:0] x;
    wr_t w;
    n = {f[0], f[1]};
    if (n > MAX_WORDS) begin
      consumed = 2; exp_done = 0; exp_err = 1; exp_words = 0;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
    for (int k = 0; k < n; k++) begin
      w.addr = ADDR_W'(k);
      w.data = {f[2+4*k], f[3+4*k], f[4+4*k], f[5+4*k]};
      exp_q.push_back(w);
    end
    consumed  = 3 + 4 * n;
    exp_done  = (f[2 + 4 * n] == x);
    exp_err   = !exp_done;
    exp_words = n;
  endtask

  function automatic logic [7:0] xor_all(input bq_t f);
    logic [7:0] x = 8'd0;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  function automatic bq_t make_frame(input int n, input bit good);
    bq_t f;
    logic [15:0] len = 16'(n);
    f.push_back(len[15:8]);
    f.push_back(len[7:0]);
    if (n <= MAX_WORDS)
      for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom_range(0, 255)));
    f.push_back(good ? xor_all(f) : xor_all(f) ^ 8'($urandom_range(1, 255)));
    return f;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1;
      else @(posedge clk);
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int max_gap,
                           input bit pin_first);
    int consumed, exp_words;
    bit exp_done, exp_err;
    model_frame(f, consumed, exp_done, exp_err, exp_words);
    if (pin_first) begin
      check("model_word0", exp_q[0].data, 32'h2008_0005);
      check("model_word1", exp_q[1].data, 32'h2109_0003);
      check("model_chk", {24'd0, xor_all(f[0:9])}, 32'h04);
    end
    pulse_start();
    for (int i = 0; i < consumed; i++)
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~exp_done});
    check({tag, "_words"}, {21'd0, words_loaded}, 32'(exp_words));
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("frame %s: N=%0d bytes=%0d done=%0b err=%0b words_loaded=%0d",
             tag, {f[0], f[1]}, consumed, done, err, words_loaded);
  endtask

  initial begin
    bq_t f;
    int  consumed, exp_words;
    bit  exp_done, exp_err;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    #12;
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_words", {21'd0, words_loaded}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    $display("reset/idle: cpu_rst=%0b in_ready=%0b", cpu_rst, in_ready);
    @(posedge clk); #1;

    f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h03, 8'h04};
    run_frame("basic", f, 0, 1);
    check("basic_last_wdata", imem_wdata, 32'h2109_0003);
    run_frame("gapped", f, 3, 0);

    f = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check("model_chk_bad", {24'd0, xor_all('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD})}, 32'h01);
    f = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    run_frame("badchk", f, 1, 0);
    check("badchk_wdata", imem_wdata, 32'hAABB_CCDD);

    f = '{8'h04, 8'h01, 8'h00};
    run_frame("toolong", f, 0, 0);
    f = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", f, 2, 0);

    for (int r = 0; r < 8; r++) begin
      f = make_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) != 0));
      run_frame($sformatf("rand%0d", r), f, 2, 0);
    end
    f = make_frame(int'($urandom_range(MAX_WORDS + 1, 65535)), 1);
    run_frame("rand_toolong", f, 1, 0);
    f = make_frame(MAX_WORDS, 1);
    f = f[0:1];
    f.push_back(8'h00);
    check("max_len_hi", {24'd0, f[0]}, 32'h04);

    // Abort after six data bytes: only the first word may have been written.
    f = make_frame(2, 1);
    model_frame(f, consumed, exp_done, exp_err, exp_words);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(f[i], 0);
    repeat (2) @(posedge clk);
    #2;
    check("abort_pending_writes", 32'(exp_q.size()), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_words", {21'd0, words_loaded}, 32'd0);
    check("abort_done_err", {30'd0, done, err}, 32'd0);
    exp_q.delete();
    $display("abort: cpu_rst=%0b in_ready=%0b words_loaded=%0d", cpu_rst, in_ready, words_loaded);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    f = make_frame(3, 1);
    run_frame("after_abort", f, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
